// File: rtl/ila_receiver.sv
// ila_receiver: follows the JESD204B ILA sequence on one lane, checks /R/ /A/ /Q/ and captures the link configuration.
// Latency: every output is registered and moves one cycle after the octet that caused it.
// Backpressure: none; i_vld low freezes all position counters, the block never stalls its source.
// Ports: i_start arms/restarts the checker; i_data/i_k/i_vld is the decoded octet stream;
//        i_F/i_K/i_ila_multiframe_length give the link geometry (all minus 1);
//        o_<field> are captured config fields, o_cfg_vld flags a config with good FCHK,
//        o_done pulses on a clean ILA end, o_err/o_err_code report the first error.
module ila_receiver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_k,
    input  logic       i_vld,
    input  logic [7:0] i_F,
    input  logic [4:0] i_K,
    input  logic [7:0] i_ila_multiframe_length,
    output logic [7:0] o_DID,
    output logic [3:0] o_BID,
    output logic [3:0] o_ADJCNT,
    output logic [4:0] o_LID,
    output logic       o_PHADJ,
    output logic       o_ADJDIR,
    output logic       o_SCR,
    output logic [4:0] o_L,
    output logic [7:0] o_F,
    output logic [4:0] o_K,
    output logic [7:0] o_M,
    output logic [1:0] o_CS,
    output logic [4:0] o_N,
    output logic [2:0] o_SUBCLASSV,
    output logic [4:0] o_N_ap,
    output logic [2:0] o_JESDV,
    output logic [4:0] o_S,
    output logic       o_HD,
    output logic [4:0] o_CF,
    output logic       o_cfg_vld,
    output logic       o_done,
    output logic       o_err,
    output logic [2:0] o_err_code
);

    typedef enum logic [1:0] {IDLE, WAIT_R, RUN, ERROR} state_t;

    localparam logic [7:0] K_R = 8'h1C;  // K28.0
    localparam logic [7:0] K_A = 8'h7C;  // K28.3
    localparam logic [7:0] K_Q = 8'h9C;  // K28.4

    state_t      state_q, state_d;
    logic [7:0]  oif_q, n_oif, p_oif;     // octet in frame
    logic [4:0]  fim_q, n_fim, p_fim;     // frame in multiframe
    logic [10:0] oim_q, n_oim, p_oim;     // octet in multiframe
    logic [7:0]  mf_q, n_mf, p_mf;        // multiframe index
    // A 12-bit sum compared mod 256 is the same as an 8-bit wrapping sum.
    logic [7:0]  fchk_acc_q, acc_d;
    logic        clr, arm, adv, err_set, done_d, sh_load, commit;
    logic [2:0]  code_d;
    logic        is_r, is_last, in_cfg;
    logic [3:0]  cfg_idx;

    logic [7:0] sh_did, sh_f, sh_m;
    logic [3:0] sh_bid, sh_adjcnt;
    logic [4:0] sh_lid, sh_l, sh_k, sh_n, sh_np, sh_s, sh_cf;
    logic       sh_phadj, sh_adjdir, sh_scr, sh_hd;
    logic [1:0] sh_cs;
    logic [2:0] sh_subv, sh_jesdv;

    // Sum of the field values carried by config octet idx (padding bits excluded).
    function automatic logic [7:0] field_sum(input logic [3:0] idx, input logic [7:0] d);
        case (idx)
            4'd0, 4'd4, 4'd6: field_sum = d;
            4'd1:             field_sum = 8'(d[3:0]) + 8'(d[7:4]);
            4'd2:             field_sum = 8'(d[4:0]) + 8'(d[5]) + 8'(d[6]);
            4'd3, 4'd10:      field_sum = 8'(d[4:0]) + 8'(d[7]);
            4'd5:             field_sum = 8'(d[4:0]);
            4'd7:             field_sum = 8'(d[4:0]) + 8'(d[7:6]);
            4'd8, 4'd9:       field_sum = 8'(d[4:0]) + 8'(d[7:5]);
            default:          field_sum = 8'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        arm     = 1'b0;
        adv     = 1'b0;
        err_set = 1'b0;
        code_d  = 3'd0;
        done_d  = 1'b0;
        sh_load = 1'b0;
        commit  = 1'b0;
        is_r    = i_vld && i_k && (i_data == K_R);
        is_last = (oif_q == i_F) && (fim_q == i_K);
        in_cfg  = (mf_q == 8'd1) && (oim_q >= 11'd2) && (oim_q <= 11'd15);
        cfg_idx = oim_q[3:0] - 4'd2;
        acc_d   = (cfg_idx == 4'd0) ? field_sum(cfg_idx, i_data)
                                    : fchk_acc_q + field_sum(cfg_idx, i_data);

        if (i_start) begin
            // Restart wins; the same octet is judged as a WAIT_R octet.
            clr     = 1'b1;
            state_d = WAIT_R;
            if (is_r) begin
                arm     = 1'b1;
                state_d = RUN;
            end
        end else begin
            case (state_q)
                WAIT_R: if (is_r) begin
                    arm     = 1'b1;
                    state_d = RUN;
                end
                RUN: if (i_vld) begin
                    if (oim_q == 11'd0) begin
                        if (!(i_k && i_data == K_R)) code_d = 3'd1;
                    end else if (is_last) begin
                        if (!(i_k && i_data == K_A)) code_d = 3'd2;
                    end else if (mf_q == 8'd1 && oim_q == 11'd1) begin
                        if (!(i_k && i_data == K_Q)) code_d = 3'd3;
                    end else if (i_k) begin
                        code_d = (i_data == K_A || i_data == K_R) ? 3'd6 : 3'd5;
                    end else if (in_cfg && cfg_idx == 4'd13 && fchk_acc_q != i_data) begin
                        code_d = 3'd4;
                    end

                    if (code_d != 3'd0) begin
                        err_set = 1'b1;
                        state_d = ERROR;
                    end else begin
                        adv     = 1'b1;
                        sh_load = in_cfg && (cfg_idx <= 4'd10);
                        commit  = in_cfg && (cfg_idx == 4'd13);
                        if (is_last && mf_q == i_ila_multiframe_length) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end

        // The accepted /R/ that arms the checker is position 0 of multiframe 0.
        p_oif = arm ? 8'd0  : oif_q;
        p_fim = arm ? 5'd0  : fim_q;
        p_oim = arm ? 11'd0 : oim_q;
        p_mf  = arm ? 8'd0  : mf_q;
        n_mf  = p_mf;
        n_fim = p_fim;
        n_oim = (p_oim == 11'h7FF) ? p_oim : p_oim + 11'd1;
        n_oif = p_oif + 8'd1;
        if (p_oif == i_F) begin
            n_oif = 8'd0;
            if (p_fim == i_K) begin
                n_fim = 5'd0;
                n_oim = 11'd0;
                n_mf  = p_mf + 8'd1;
            end else begin
                n_fim = p_fim + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oif_q <= '0; fim_q <= '0; oim_q <= '0; mf_q <= '0; fchk_acc_q <= '0;
            sh_did <= '0; sh_bid <= '0; sh_adjcnt <= '0; sh_lid <= '0; sh_phadj <= 1'b0;
            sh_adjdir <= 1'b0; sh_scr <= 1'b0; sh_l <= '0; sh_f <= '0; sh_k <= '0;
            sh_m <= '0; sh_cs <= '0; sh_n <= '0; sh_subv <= '0; sh_np <= '0;
            sh_jesdv <= '0; sh_s <= '0; sh_hd <= 1'b0; sh_cf <= '0;
            o_DID <= '0; o_BID <= '0; o_ADJCNT <= '0; o_LID <= '0; o_PHADJ <= 1'b0;
            o_ADJDIR <= 1'b0; o_SCR <= 1'b0; o_L <= '0; o_F <= '0; o_K <= '0;
            o_M <= '0; o_CS <= '0; o_N <= '0; o_SUBCLASSV <= '0; o_N_ap <= '0;
            o_JESDV <= '0; o_S <= '0; o_HD <= 1'b0; o_CF <= '0;
            o_cfg_vld <= 1'b0; o_done <= 1'b0; o_err <= 1'b0; o_err_code <= '0;
        end else begin
            o_done <= done_d;
            if (clr) begin
                o_err      <= 1'b0;
                o_err_code <= '0;
                o_cfg_vld  <= 1'b0;
            end
            if (err_set) begin
                o_err      <= 1'b1;
                o_err_code <= code_d;
            end
            if (arm || adv) begin
                oif_q <= n_oif; fim_q <= n_fim; oim_q <= n_oim; mf_q <= n_mf;
            end
            if (sh_load) begin
                fchk_acc_q <= acc_d;
                case (cfg_idx)
                    4'd0:  sh_did <= i_data;
                    4'd1:  begin sh_adjcnt <= i_data[7:4]; sh_bid <= i_data[3:0]; end
                    4'd2:  begin sh_adjdir <= i_data[6]; sh_phadj <= i_data[5]; sh_lid <= i_data[4:0]; end
                    4'd3:  begin sh_scr <= i_data[7]; sh_l <= i_data[4:0]; end
                    4'd4:  sh_f <= i_data;
                    4'd5:  sh_k <= i_data[4:0];
                    4'd6:  sh_m <= i_data;
                    4'd7:  begin sh_cs <= i_data[7:6]; sh_n <= i_data[4:0]; end
                    4'd8:  begin sh_subv <= i_data[7:5]; sh_np <= i_data[4:0]; end
                    4'd9:  begin sh_jesdv <= i_data[7:5]; sh_s <= i_data[4:0]; end
                    4'd10: begin sh_hd <= i_data[7]; sh_cf <= i_data[4:0]; end
                    default: ;
                endcase
            end
            if (commit) begin
                o_DID <= sh_did; o_BID <= sh_bid; o_ADJCNT <= sh_adjcnt; o_LID <= sh_lid;
                o_PHADJ <= sh_phadj; o_ADJDIR <= sh_adjdir; o_SCR <= sh_scr; o_L <= sh_l;
                o_F <= sh_f; o_K <= sh_k; o_M <= sh_m; o_CS <= sh_cs; o_N <= sh_n;
                o_SUBCLASSV <= sh_subv; o_N_ap <= sh_np; o_JESDV <= sh_jesdv; o_S <= sh_s;
                o_HD <= sh_hd; o_CF <= sh_cf;
                o_cfg_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ila_receiver.sv
module tb_ila_receiver;

    typedef struct packed {
        logic       vld;
        logic       k;
        logic [7:0] d;
    } oct_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start, i_k, i_vld;
    logic [7:0] i_data, i_F, i_ila_multiframe_length;
    logic [4:0] i_K;
    logic [7:0] o_DID, o_F, o_M;
    logic [3:0] o_BID, o_ADJCNT;
    logic [4:0] o_LID, o_L, o_K, o_N, o_N_ap, o_S, o_CF;
    logic       o_PHADJ, o_ADJDIR, o_SCR, o_HD, o_cfg_vld, o_done, o_err;
    logic [1:0] o_CS;
    logic [2:0] o_SUBCLASSV, o_JESDV, o_err_code;

    ila_receiver dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_data(i_data), .i_k(i_k), .i_vld(i_vld),
        .i_F(i_F), .i_K(i_K), .i_ila_multiframe_length(i_ila_multiframe_length),
        .o_DID(o_DID), .o_BID(o_BID), .o_ADJCNT(o_ADJCNT), .o_LID(o_LID), .o_PHADJ(o_PHADJ),
        .o_ADJDIR(o_ADJDIR), .o_SCR(o_SCR), .o_L(o_L), .o_F(o_F), .o_K(o_K), .o_M(o_M),
        .o_CS(o_CS), .o_N(o_N), .o_SUBCLASSV(o_SUBCLASSV), .o_N_ap(o_N_ap), .o_JESDV(o_JESDV),
        .o_S(o_S), .o_HD(o_HD), .o_CF(o_CF), .o_cfg_vld(o_cfg_vld), .o_done(o_done),
        .o_err(o_err), .o_err_code(o_err_code)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int done_seen;

    // Transmit-side picture of the link configuration.
    logic [7:0] f_did, f_f, f_m;
    logic [3:0] f_bid, f_adjcnt;
    logic [4:0] f_lid, f_l, f_k, f_n, f_np, f_s, f_cf;
    logic       f_phadj, f_adjdir, f_scr, f_hd;
    logic [1:0] f_cs;
    logic [2:0] f_subv, f_jesdv;
    logic [7:0] gen_fchk;
    logic [7:0] cfgo [14];

    oct_t strm [$];
    int   idx_q, idx_fchk, idx_a2, idx_d3;
    int   exp_err_idx, exp_code, exp_done_idx, exp_cfg_idx;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_fields();
        f_did = 8'($urandom); f_bid = 4'($urandom); f_adjcnt = 4'($urandom);
        f_lid = 5'($urandom); f_phadj = 1'($urandom); f_adjdir = 1'($urandom);
        f_scr = 1'($urandom); f_l = 5'($urandom); f_f = 8'($urandom); f_k = 5'($urandom);
        f_m = 8'($urandom); f_cs = 2'($urandom); f_n = 5'($urandom); f_subv = 3'($urandom);
        f_np = 5'($urandom); f_jesdv = 3'($urandom); f_s = 5'($urandom);
        f_hd = 1'($urandom); f_cf = 5'($urandom);
    endtask

    task automatic build_cfg();
        int sum;
        sum = int'(f_did) + int'(f_bid) + int'(f_adjcnt) + int'(f_lid) + int'(f_phadj)
            + int'(f_adjdir) + int'(f_scr) + int'(f_l) + int'(f_f) + int'(f_k) + int'(f_m)
            + int'(f_cs) + int'(f_n) + int'(f_subv) + int'(f_np) + int'(f_jesdv) + int'(f_s)
            + int'(f_hd) + int'(f_cf);
        gen_fchk = 8'(sum % 256);
        cfgo[0] = f_did;                       cfgo[1]  = {f_adjcnt, f_bid};
        cfgo[2] = {1'b0, f_adjdir, f_phadj, f_lid};
        cfgo[3] = {f_scr, 2'b00, f_l};         cfgo[4]  = f_f;
        cfgo[5] = {3'b000, f_k};               cfgo[6]  = f_m;
        cfgo[7] = {f_cs, 1'b0, f_n};           cfgo[8]  = {f_subv, f_np};
        cfgo[9] = {f_jesdv, f_s};              cfgo[10] = {f_hd, 2'b00, f_cf};
        cfgo[11] = 8'($urandom);               cfgo[12] = 8'($urandom);
        cfgo[13] = gen_fchk;
    endtask

    // Transmit-generator ILA: optional /K/ prefix, (len+1) multiframes, random idle gaps.
    task automatic gen(input int prefix, input int gap_pct);
        int   mfl;
        oct_t o;
        strm.delete();
        mfl = (int'(i_F) + 1) * (int'(i_K) + 1);
        for (int p = 0; p < prefix; p++) strm.push_back({1'b1, 1'b1, 8'hBC});
        for (int mf = 0; mf <= int'(i_ila_multiframe_length); mf++) begin
            for (int pos = 0; pos < mfl; pos++) begin
                while (int'($urandom_range(0, 99)) < gap_pct)
                    strm.push_back({1'b0, 1'($urandom), 8'($urandom)});
                if (mf == 1 && pos == 1)       idx_q    = strm.size();
                if (mf == 1 && pos == 15)      idx_fchk = strm.size();
                if (mf == 2 && pos == mfl - 1) idx_a2   = strm.size();
                if (mf == 3 && pos == 2)       idx_d3   = strm.size();
                if (pos == 0)                         o = {1'b1, 1'b1, 8'h1C};
                else if (pos == mfl - 1)              o = {1'b1, 1'b1, 8'h7C};
                else if (mf == 1 && pos == 1)         o = {1'b1, 1'b1, 8'h9C};
                else if (mf == 1 && pos <= 15)        o = {1'b1, 1'b0, cfgo[pos - 2]};
                else                                  o = {1'b1, 1'b0, 8'($urandom)};
                strm.push_back(o);
            end
        end
        repeat (3) strm.push_back({1'b1, 1'b0, 8'($urandom)});
    endtask

    task automatic poke(input int idx, input logic k, input logic [7:0] d);
        oct_t o;
        o = strm[idx];
        o.k = k;
        o.d = d;
        strm[idx] = o;
    endtask

    // Walks the stream by absolute position (multiframe = n / length, offset = n % length).
    task automatic model();
        int  n, mfl, mf, pos, code;
        bit  run;
        exp_err_idx = -1; exp_code = 0; exp_done_idx = -1; exp_cfg_idx = -1;
        run = 0; n = 0;
        mfl = (int'(i_F) + 1) * (int'(i_K) + 1);
        for (int i = 0; i < strm.size(); i++) begin
            if (!strm[i].vld) continue;
            if (!run) begin
                if (strm[i].k && strm[i].d == 8'h1C) begin run = 1; n = 1; end
                continue;
            end
            mf = n / mfl; pos = n % mfl; code = 0;
            if (pos == 0) begin
                if (!(strm[i].k && strm[i].d == 8'h1C)) code = 1;
            end else if (pos == mfl - 1) begin
                if (!(strm[i].k && strm[i].d == 8'h7C)) code = 2;
            end else if (mf == 1 && pos == 1) begin
                if (!(strm[i].k && strm[i].d == 8'h9C)) code = 3;
            end else if (strm[i].k) begin
                code = (strm[i].d == 8'h7C || strm[i].d == 8'h1C) ? 6 : 5;
            end else if (mf == 1 && pos == 15 && strm[i].d != gen_fchk) begin
                code = 4;
            end
            if (code != 0) begin exp_err_idx = i; exp_code = code; break; end
            if (mf == 1 && pos == 15) exp_cfg_idx = i;
            if (pos == mfl - 1 && mf == int'(i_ila_multiframe_length)) begin
                exp_done_idx = i;
                break;
            end
            n++;
        end
    endtask

    task automatic check_cycle(input int i);
        bit e;
        e = (exp_err_idx >= 0) && (i >= exp_err_idx);
        if (o_done === 1'b1) done_seen++;
        chk($sformatf("done@%0d", i), 96'(o_done), 96'(i == exp_done_idx));
        chk($sformatf("err@%0d", i), 96'(o_err), 96'(e));
        chk($sformatf("err_code@%0d", i), 96'(o_err_code), 96'(e ? exp_code : 0));
        chk($sformatf("cfg_vld@%0d", i), 96'(o_cfg_vld),
            96'((exp_cfg_idx >= 0) && (i >= exp_cfg_idx)));
    endtask

    task automatic run_stream(input int upto);
        done_seen = 0;
        for (int i = 0; i < upto; i++) begin
            @(negedge clk);
            if (i > 0) check_cycle(i - 1);
            i_start = (i == 0);
            i_vld   = strm[i].vld;
            i_k     = strm[i].k;
            i_data  = strm[i].d;
        end
        @(negedge clk);
        check_cycle(upto - 1);
        i_start = 1'b0; i_vld = 1'b0; i_k = 1'b0; i_data = 8'h00;
    endtask

    task automatic check_fields(input string tag);
        chk({tag, ".DID"}, 96'(o_DID), 96'(f_did));       chk({tag, ".BID"}, 96'(o_BID), 96'(f_bid));
        chk({tag, ".ADJCNT"}, 96'(o_ADJCNT), 96'(f_adjcnt)); chk({tag, ".LID"}, 96'(o_LID), 96'(f_lid));
        chk({tag, ".PHADJ"}, 96'(o_PHADJ), 96'(f_phadj)); chk({tag, ".ADJDIR"}, 96'(o_ADJDIR), 96'(f_adjdir));
        chk({tag, ".SCR"}, 96'(o_SCR), 96'(f_scr));       chk({tag, ".L"}, 96'(o_L), 96'(f_l));
        chk({tag, ".F"}, 96'(o_F), 96'(f_f));             chk({tag, ".K"}, 96'(o_K), 96'(f_k));
        chk({tag, ".M"}, 96'(o_M), 96'(f_m));             chk({tag, ".CS"}, 96'(o_CS), 96'(f_cs));
        chk({tag, ".N"}, 96'(o_N), 96'(f_n));             chk({tag, ".SUBCLASSV"}, 96'(o_SUBCLASSV), 96'(f_subv));
        chk({tag, ".N_ap"}, 96'(o_N_ap), 96'(f_np));      chk({tag, ".JESDV"}, 96'(o_JESDV), 96'(f_jesdv));
        chk({tag, ".S"}, 96'(o_S), 96'(f_s));             chk({tag, ".HD"}, 96'(o_HD), 96'(f_hd));
        chk({tag, ".CF"}, 96'(o_CF), 96'(f_cf));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".fields"}, 96'({o_DID, o_BID, o_ADJCNT, o_LID, o_PHADJ, o_ADJDIR, o_SCR, o_L,
            o_F, o_K, o_M, o_CS, o_N, o_SUBCLASSV, o_N_ap, o_JESDV, o_S, o_HD, o_CF}), 96'(0));
        chk({tag, ".cfg_vld"}, 96'(o_cfg_vld), 96'(0));
        chk({tag, ".done"}, 96'(o_done), 96'(0));
        chk({tag, ".err"}, 96'(o_err), 96'(0));
        chk({tag, ".err_code"}, 96'(o_err_code), 96'(0));
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_vld = 1'b0; i_k = 1'b0; i_data = 8'h00;
        i_F = 8'd1; i_K = 5'd15; i_ila_multiframe_length = 8'd3;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal 32-octet multiframes, four of them.
        rand_fields(); f_did = 8'h5A; f_l = 5'd3; build_cfg();
        gen(4, 0); model(); run_stream(strm.size());
        check_fields("nominal");
        chk("nominal.DID_5A", 96'(o_DID), 96'(8'h5A));
        chk("nominal.L_3", 96'(o_L), 96'(5'd3));
        chk("nominal.done_count", 96'(done_seen), 96'(1));

        // FCHK off by one.
        gen(4, 0); poke(idx_fchk, 1'b0, gen_fchk + 8'd1); model(); run_stream(strm.size());
        chk("fchk.err_code", 96'(o_err_code), 96'(4));
        chk("fchk.cfg_vld", 96'(o_cfg_vld), 96'(0));
        chk("fchk.done_count", 96'(done_seen), 96'(0));

        // /Q/ replaced by plain data 0x00.
        gen(4, 0); poke(idx_q, 1'b0, 8'h00); model(); run_stream(strm.size());
        chk("noq.err_code", 96'(o_err_code), 96'(3));

        // Missing /A/ closing multiframe 2, then a stray K28.5: first error must stick.
        gen(4, 0); poke(idx_a2, 1'b0, 8'h33); poke(idx_d3, 1'b1, 8'hBC);
        model(); run_stream(strm.size());
        chk("noa.err_code", 96'(o_err_code), 96'(2));
        chk("noa.done_count", 96'(done_seen), 96'(0));

        // Nominal with random i_vld gaps.
        gen(4, 30); model(); run_stream(strm.size());
        check_fields("gaps");
        chk("gaps.done_count", 96'(done_seen), 96'(1));

        // Random geometry, i_start coincident with the first /R/.
        i_F = 8'($urandom_range(0, 3)); i_K = 5'($urandom_range(16, 31));
        i_ila_multiframe_length = 8'($urandom_range(1, 3));
        rand_fields(); build_cfg();
        gen(0, 20); model(); run_stream(strm.size());
        check_fields("geom");
        chk("geom.done_count", 96'(done_seen), 96'(1));

        // Asynchronous reset in the middle of multiframe 2, then a clean rerun.
        i_F = 8'd1; i_K = 5'd15; i_ila_multiframe_length = 8'd3;
        rand_fields(); build_cfg();
        gen(4, 0); model(); run_stream(idx_a2);
        #2 rst_n = 1'b0;
        #1 check_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_stream(strm.size());
        check_fields("after_rst");
        chk("after_rst.done_count", 96'(done_seen), 96'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ila_receiver.md
# ila_receiver

Receive-side companion to the transmit ILA generator in the JESD204B link layer. It sits after 8b/10b decode and code-group synchronisation on one lane. It tracks the Initial Lane Alignment sequence octet by octet and checks the /R/, /A/ and /Q/ control characters. It also captures and checksums the 14 link-configuration octets and reports completion or the first error to the RX link-layer controller.

## Interface

- No parameters. All link geometry comes from ports.
- clk  input  1  character clock
- rst_n  input  1  reset, asynchronous, active-low
- i_start  input  1  one-cycle pulse: CGS complete, arm the checker (restarts it from any state)
- i_data  input  8  decoded octet, HGFEDCBA
- i_k  input  1  i_data is a control character
- i_vld  input  1  octet valid; when low the octet is ignored and all counters hold
- i_F  input  8  octets per frame minus 1
- i_K  input  5  frames per multiframe minus 1
- i_ila_multiframe_length  input  8  ILA multiframes minus 1 (must be ≥ 1)
- o_DID 8, o_BID 4, o_ADJCNT 4, o_LID 5, o_PHADJ 1, o_ADJDIR 1, o_SCR 1, o_L 5, o_F 8, o_K 5, o_M 8, o_CS 2, o_N 5, o_SUBCLASSV 3, o_N_ap 5, o_JESDV 3, o_S 5, o_HD 1, o_CF 5  output: captured config fields, encoded as on the wire
- o_cfg_vld  output  1  config captured and FCHK correct
- o_done  output  1  one-cycle pulse: ILA ended without error
- o_err  output  1  latched error flag
- o_err_code  output  3  first error: 1 no /R/, 2 no /A/, 3 no /Q/, 4 FCHK mismatch, 5 K-char in data, 6 early /A/ or /R/

## Operation

- States: IDLE, WAIT_R, RUN, ERROR.
- IDLE: on i_start, go to WAIT_R and clear o_err, o_err_code and o_cfg_vld.
- WAIT_R: discard octets (normally K28.5). A valid octet equal to K28.0 with i_k=1 is octet 0 of multiframe 0; go to RUN.
- RUN counters:
  - octet-in-frame, 0..i_F
  - frame-in-multiframe, 0..i_K
  - octet-in-multiframe, 0..(i_F+1)(i_K+1)-1, 11 bits
  - multiframe index, 8 bits
  - All counters advance only on i_vld.
- Expected octet at each position, checked in priority order:
  - Octet 0 of every multiframe: K28.0 (0x1C, k=1), else code 1.
  - Last octet of every multiframe: K28.3 (0x7C, k=1), else code 2.
  - Multiframe 1, octet 1: K28.4 (0x9C, k=1), else code 3.
  - Multiframe 1, octets 2..15: link config, config index 0..13, k must be 0.
  - Any other position: data with k=0. K28.3 or K28.0 there gives code 6; any other k=1 gives code 5.
- Config octet layout:
  - 0: DID
  - 1: {ADJCNT, BID}
  - 2: {0, ADJDIR, PHADJ, LID}
  - 3: {SCR, 00, L}
  - 4: F
  - 5: {000, K}
  - 6: M
  - 7: {CS, 0, N}
  - 8: {SUBCLASSV, N'}
  - 9: {JESDV, S}
  - 10: {HD, 00, CF}
  - 11, 12: reserved, not checked
  - 13: FCHK
- Fields load into shadow registers as each octet arrives. Outputs update only at index 13.
- FCHK: 12-bit accumulator of all field values (not whole octets) for indices 0..10, compared mod 256 with octet 13. Mismatch gives code 4.
- The error-free completion path is when the last octet of multiframe i_ila_multiframe_length is a correct /A/: pulse o_done, go to IDLE.
- Any error: set o_err, load o_err_code, go to ERROR. ERROR holds until i_start.
- i_start in RUN or ERROR restarts in WAIT_R; o_cfg_vld and error state clear.

## Timing

- Reset: state IDLE, all field outputs 0, o_cfg_vld=0, o_done=0, o_err=0, o_err_code=0.
- All outputs are registered, 1-cycle latency from the accepted octet:
  - o_err and o_err_code assert the cycle after the offending octet.
  - Fields and o_cfg_vld update the cycle after the FCHK octet. o_cfg_vld stays high until i_start or reset.
  - o_done is high exactly one cycle, the cycle after the final /A/.
- i_start has priority over octet processing in the same cycle; that octet is treated as a WAIT_R octet. An i_start that is coincident with K28.0 arms and accepts it as multiframe 0.
- Only the first error is recorded; later octets are ignored.
- Wrap: octet-in-frame resets at i_F and frame-in-multiframe at i_K. The multiframe index increments at the end of each multiframe.

## Test plan

- Nominal: i_F=1, i_K=15 (32 octets per multiframe), length=3, sequence from the TX generator with DID=0x5A, L=3, FCHK correct. Required: o_cfg_vld=1 with o_DID=0x5A, o_L=3, and o_done pulses once, 1 cycle after the 128th octet; o_err=0.
- FCHK octet corrupted by +1. Required: o_err=1, o_err_code=4, o_cfg_vld=0, no o_done.
- K28.4 in multiframe 1 replaced by 0x00 with k=0. Required: o_err_code=3, 1 cycle after that octet.
- The /A/ at the end of multiframe 2 dropped (data instead), then a K28.5 inserted at a data position. Required: o_err_code=2 only, with the first error kept.
- i_vld low for random gaps across the nominal sequence. Required: identical results to the nominal case and o_done timing shifted only by the gap count.
- rst_n asserted in mid-RUN. Required: all outputs return to reset values immediately; a following i_start plus the nominal sequence passes.
